kfx86_shift_unit: RTL and testbench
===================================

// Module: kfx86_shift_unit
// PURPOSE
//  Iterative multi-bit shift/rotate engine for the KFX86 execution unit. It implements
//  ROL/ROR/RCL/RCR/SHL/SHR/SAR by an arbitrary count (8086 "shift r/m,CL" semantics).
//  Each clock it performs one single-bit step, so the cost is count cycles.
//  It sits beside the combinational ALU and is launched by the microsequencer.
//  Handshake: start/busy/done.
// PARAMETERS
//  WIDTH        16  operand width in word mode; byte mode always uses bits [7:0]
//  COUNT_WIDTH  8   width of the shift count input (CL)
// PORTS
//  clock         in   1            system clock
//  reset         in   1            synchronous, active-high reset
//  start         in   1            launch request; accepted only in IDLE
//  opcode        in   3            shift_op_t (from package)
//  select_word   in   1            1 = WIDTH-bit operation, 0 = byte operation on [7:0]
//  source        in   WIDTH        operand
//  count         in   COUNT_WIDTH  shift count
//  source_flags  in   flags_t      incoming flags (C is the carry-in for RCL/RCR)
//  busy          out  1            operation in progress
//  done          out  1            one-cycle pulse; result/out_flags are valid
//  result        out  WIDTH        shifted value; bits above [7:0] are zero in byte mode
//  out_flags     out  flags_t      updated flags
// BEHAVIOUR
//  Interface
//   - One clock (clock). reset is synchronous and active-high.
//   - Reset: FSM goes to IDLE; busy=0, done=0, result=0, out_flags=0.
//   - Reset mid-operation aborts the operation; no done pulse is produced.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE
//   - IDLE: on start, latch opcode, select_word, source, count and source_flags.
//     - Masked count == 0: go to DONE; result = source (byte-masked); out_flags = source_flags.
//     - Otherwise: go to SHIFT.
//   - SHIFT: busy=1. Each cycle: one 1-bit step, then remaining count -= 1.
//     When the step leaves remaining count == 0, go to DONE.
//   - DONE: done=1 for exactly one cycle, busy=0; return to IDLE.
//   - result and out_flags hold their values until the next accepted start.
//  Timing and handshake
//   - Latency from start cycle to done cycle: N+1 clocks for count N (N >= 0).
//   - start is ignored while in SHIFT or DONE.
//   - start in the same cycle as reset is dropped.
//  Single-step rules (n = 8 or WIDTH; msb = bit n-1)
//   - ROL: C = msb;  v = {v[n-2:0], msb};  O = C ^ new msb
//   - ROR: C = v[0]; v = {v[0], v[n-1:1]}; O = new msb ^ new msb-1
//   - RCL: v = {v[n-2:0], C}, C = old msb; O = C ^ new msb
//   - RCR: v = {C, v[n-1:1]}, C = old v[0]; O = new msb ^ new msb-1
//   - SHL: C = msb;  v = {v[n-2:0], 0};  O = C ^ new msb
//   - SHR: C = v[0]; v = {0, v[n-1:1]};  O = old msb
//   - SAR: C = v[0]; v = {msb, v[n-1:1]}; O = 0
//  Flag updates
//   - O reflects the final step only.
//   - Shifts (SHL/SHR/SAR) with N > 0 also update P (even parity of [7:0]),
//     Z (result == 0) and S (msb).
//   - Rotates leave P, Z and S untouched.
//   - A is never modified.
//   - Counts >= n are legal: shifting simply continues; C tracks the last bit out.
// CONFIGURATION
//  KFX86_SHIFT_COUNT_MASK_EN
//   - Defined: count is masked to count[4:0] at launch (80186 behaviour); max 31 steps.
//   - Undefined: the full COUNT_WIDTH count is used (8088 behaviour); up to 255 steps.
// STRUCTURE
//  - Package kfx86_shift_pkg: shift_op_t enum (ROL=0, ROR=1, RCL=2, RCR=3, SHL=4, SHR=5,
//    SAR=7; 6 aliases SHL), fsm state_t enum, and a shared parity function.
//  - flags_t comes from the existing accumulator header.
//  - One sub-module: kfx86_shift_step. It is the combinational single-bit step
//    (op, select_word, value, flags -> value, flags) and is reused by the microcode ALU.
// TESTING
//  1. SHL, word, source 0x8001, count 1
//     -> done 2 clocks after start; result 0x0002; C=1, O=1, Z=0, S=0.
//  2. ROR, byte, source 0x01, count 3
//     -> result 0x0020; C=0, O=0; done on the 4th clock.
//  3. SAR, word, source 0x8000, count 15
//     -> result 0xFFFF; C=0, S=1, Z=0, P=1, O=0.
//  4. RCL, byte, source 0x80, C_in 0, count 2
//     -> result 0x0001; C=0, O=0.
//  5. SHR, word, source 0x1234, count 0
//     -> done after 1 clock; result 0x1234; out_flags == source_flags.
//  6. SHL, word, source 0x0001, count 0x21
//     -> macro defined: result 0x0002 after 2 clocks.
//     -> macro undefined: result 0x0000, Z=1, C=0 after 34 clocks.
//  7. Reset on the 3rd SHIFT cycle
//     -> next cycle busy=0, done=0, result=0.
//     -> a following start with count 1 completes normally.
//  8. start re-asserted while busy
//     -> ignored; the original result is unaffected.

Source files
------------

// File: rtl/kfx86_shift_pkg.sv
// kfx86_shift_pkg
//   Shared types for the KFX86 shift/rotate engine and the microcode ALU:
//   - flags_t    : accumulator flag layout {O,S,Z,A,P,C}
//   - shift_op_t : shift/rotate opcode (6 is an alias of SHL, i.e. SAL)
//   - state_t    : shift engine FSM state
//   - parity_even: x86 P flag (1 when the low byte has an even number of ones)
package kfx86_shift_pkg;

   typedef struct packed {
      logic o;
      logic s;
      logic z;
      logic a;
      logic p;
      logic c;
   } flags_t;

   typedef enum logic [2:0] {
      OP_ROL = 3'd0,
      OP_ROR = 3'd1,
      OP_RCL = 3'd2,
      OP_RCR = 3'd3,
      OP_SHL = 3'd4,
      OP_SHR = 3'd5,
      OP_SAL = 3'd6,
      OP_SAR = 3'd7
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic parity_even(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/kfx86_shift_step.sv
// kfx86_shift_step
//   Combinational single-bit shift/rotate step, shared with the microcode ALU.
//   Byte mode operates on value[7:0] and forces the upper bits to zero.
// Ports
//   op          in   shift_op_t  operation
//   select_word in   1           1 = WIDTH-bit step, 0 = byte step
//   value_in    in   WIDTH       operand before the step
//   flags_in    in   flags_t     flags before the step (C is the RCL/RCR carry-in)
//   value_out   out  WIDTH       operand after the step
//   flags_out   out  flags_t     flags after the step
module kfx86_shift_step
   import kfx86_shift_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  shift_op_t        op,
   input  logic             select_word,
   input  logic [WIDTH-1:0] value_in,
   input  flags_t           flags_in,
   output logic [WIDTH-1:0] value_out,
   output flags_t           flags_out
);

   logic is_left;
   logic is_shift;
   logic old_msb;
   logic fill;
   logic new_msb;
   logic new_msb1;
   logic c_out;

   always_comb begin
      is_left  = (op == OP_ROL) || (op == OP_RCL) || (op == OP_SHL) || (op == OP_SAL);
      is_shift = (op == OP_SHL) || (op == OP_SAL) || (op == OP_SHR) || (op == OP_SAR);
      old_msb  = select_word ? value_in[WIDTH-1] : value_in[7];

      // bit entering the vacated position (bit 0 for left, msb for right)
      unique case (op)
         OP_ROL:  fill = old_msb;
         OP_ROR:  fill = value_in[0];
         OP_RCL,
         OP_RCR:  fill = flags_in.c;
         OP_SAR:  fill = old_msb;
         default: fill = 1'b0;
      endcase

      if (is_left)
         value_out = select_word ? {value_in[WIDTH-2:0], fill}
                                 : {{(WIDTH-8){1'b0}}, value_in[6:0], fill};
      else
         value_out = select_word ? {fill, value_in[WIDTH-1:1]}
                                 : {{(WIDTH-8){1'b0}}, fill, value_in[7:1]};

      new_msb  = select_word ? value_out[WIDTH-1] : value_out[7];
      new_msb1 = select_word ? value_out[WIDTH-2] : value_out[6];
      c_out    = is_left ? old_msb : value_in[0];

      flags_out   = flags_in;
      flags_out.c = c_out;
      unique case (op)
         OP_ROR, OP_RCR: flags_out.o = new_msb ^ new_msb1;
         OP_SHR:         flags_out.o = old_msb;
         OP_SAR:         flags_out.o = 1'b0;
         default:        flags_out.o = c_out ^ new_msb;
      endcase

      if (is_shift) begin
         flags_out.p = parity_even(value_out[7:0]);
         flags_out.z = (value_out == '0);
         flags_out.s = new_msb;
      end
   end

endmodule

// File: rtl/kfx86_shift_unit.sv
// kfx86_shift_unit
//   Iterative shift/rotate engine (8086 "shift r/m,CL"): one bit per clock,
//   start-to-done latency count+1 clocks. FSM IDLE -> SHIFT -> DONE -> IDLE.
//   Build option KFX86_SHIFT_COUNT_MASK_EN: mask count to 5 bits at launch
//   (80186 behaviour); otherwise the full count is used (8088 behaviour).
// Ports
//   clock, reset  in   clock, synchronous active-high reset
//   start         in   launch request, accepted only in IDLE
//   opcode        in   shift_op_t
//   select_word   in   1 = WIDTH-bit op, 0 = byte op on [7:0]
//   source        in   operand
//   count         in   shift count (CL)
//   source_flags  in   incoming flags
//   busy          out  operation in progress
//   done          out  one-cycle pulse, result/out_flags valid
//   result        out  shifted value (upper bits zero in byte mode)
//   out_flags     out  updated flags
module kfx86_shift_unit
   import kfx86_shift_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  shift_op_t              opcode,
   input  logic                   select_word,
   input  logic [WIDTH-1:0]       source,
   input  logic [COUNT_WIDTH-1:0] count,
   input  flags_t                 source_flags,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       result,
   output flags_t                 out_flags
);

   typedef struct packed {
      shift_op_t op;
      logic      word;
   } req_t;

   state_t                 state_q, state_d;
   req_t                   req_q;
   logic [WIDTH-1:0]       val_q;
   flags_t                 flg_q;
   logic [COUNT_WIDTH-1:0] rem_q;
   logic [WIDTH-1:0]       result_q;
   flags_t                 out_flags_q;

   logic [WIDTH-1:0]       src_masked;
   logic [COUNT_WIDTH-1:0] cnt_eff;
   logic [WIDTH-1:0]       step_val;
   flags_t                 step_flg;

   always_comb begin
      src_masked = select_word ? source : {{(WIDTH-8){1'b0}}, source[7:0]};
`ifdef KFX86_SHIFT_COUNT_MASK_EN
      cnt_eff = count & COUNT_WIDTH'(5'h1F);
`else
      cnt_eff = count;
`endif
   end

   kfx86_shift_step #(.WIDTH(WIDTH)) u_step (
      .op          (req_q.op),
      .select_word (req_q.word),
      .value_in    (val_q),
      .flags_in    (flg_q),
      .value_out   (step_val),
      .flags_out   (step_flg)
   );

   // state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = (cnt_eff == '0) ? ST_DONE : ST_SHIFT;
         ST_SHIFT: if (rem_q == COUNT_WIDTH'(1)) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // datapath: working value iterates in val_q/flg_q; result/out_flags are
   // only written on completion so they stay stable while shifting
   always_ff @(posedge clock) begin
      if (reset) begin
         req_q       <= '{op: OP_ROL, word: 1'b0};
         val_q       <= '0;
         flg_q       <= '0;
         rem_q       <= '0;
         result_q    <= '0;
         out_flags_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: if (start) begin
               req_q <= '{op: opcode, word: select_word};
               val_q <= src_masked;
               flg_q <= source_flags;
               rem_q <= cnt_eff;
               if (cnt_eff == '0) begin
                  result_q    <= src_masked;
                  out_flags_q <= source_flags;
               end
            end
            ST_SHIFT: begin
               val_q <= step_val;
               flg_q <= step_flg;
               rem_q <= rem_q - COUNT_WIDTH'(1);
               if (rem_q == COUNT_WIDTH'(1)) begin
                  result_q    <= step_val;
                  out_flags_q <= step_flg;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q == ST_SHIFT);
   assign done      = (state_q == ST_DONE);
   assign result    = result_q;
   assign out_flags = out_flags_q;

endmodule

// File: tb/tb_kfx86_shift_unit.sv
module tb_kfx86_shift_unit;
   import kfx86_shift_pkg::*;

   logic        clock = 1'b0;
   logic        reset, start, select_word;
   shift_op_t   opcode;
   logic [15:0] source;
   logic [7:0]  count;
   flags_t      source_flags;
   logic        busy, done;
   logic [15:0] result;
   flags_t      out_flags;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   kfx86_shift_unit #(.WIDTH(16), .COUNT_WIDTH(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .opcode       (opcode),
      .select_word  (select_word),
      .source       (source),
      .count        (count),
      .source_flags (source_flags),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .out_flags    (out_flags)
   );

   typedef struct {
      string       name;
      shift_op_t   op;
      bit          word;
      logic [15:0] src;
      logic [7:0]  cnt;
      flags_t      fin;
      logic [15:0] exp_res;
      flags_t      exp_fl;
      int          exp_lat;
   } vec_t;

   function automatic vec_t mk(string nm, shift_op_t op, bit w, logic [15:0] s, logic [7:0] c,
                               logic [5:0] fi, logic [15:0] er, logic [5:0] ef, int el);
      vec_t v;
      v.name = nm; v.op = op; v.word = w; v.src = s; v.cnt = c;
      v.fin = flags_t'(fi); v.exp_res = er; v.exp_fl = flags_t'(ef); v.exp_lat = el;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: closed-form results from the shift/rotate definitions
   // (rotate by count mod width, carry = last bit shifted out).
   function automatic void model(input shift_op_t op, input bit w, input logic [15:0] src,
                                 input int nc, input flags_t fi,
                                 output logic [15:0] res, output flags_t fo);
      int n, m, k;
      logic [31:0] mask, mmask, s, r, e, sext;
      bit c, o, msb;
      n = w ? 16 : 8;
      m = n + 1;
      mask  = (32'd1 << n) - 1;
      mmask = (32'd1 << m) - 1;
      s   = {16'd0, src} & mask;
      msb = s[n-1];
      fo  = fi;
      r   = s;
      c   = 1'b0;
      o   = 1'b0;
      if (nc == 0) begin
         res = s[15:0];
         return;
      end
      k = nc % n;
      e = s | ({31'd0, fi.c} << n);
      case (op)
         OP_ROL: begin
            r = ((s << k) | (s >> (n - k))) & mask; c = r[0]; o = c ^ r[n-1];
         end
         OP_ROR: begin
            r = ((s >> k) | (s << (n - k))) & mask; c = r[n-1]; o = r[n-1] ^ r[n-2];
         end
         OP_RCL: begin
            k = nc % m;
            e = ((e << k) | (e >> (m - k))) & mmask;
            r = e & mask; c = e[n]; o = c ^ r[n-1];
         end
         OP_RCR: begin
            k = nc % m;
            e = ((e >> k) | (e << (m - k))) & mmask;
            r = e & mask; c = e[n]; o = r[n-1] ^ r[n-2];
         end
         OP_SHL, OP_SAL: begin
            r = (s << nc) & mask; c = (nc <= n) ? s[n-nc] : 1'b0; o = c ^ r[n-1];
         end
         OP_SHR: begin
            r = s >> nc; c = (nc <= n) ? s[nc-1] : 1'b0; o = (nc == 1) ? msb : 1'b0;
         end
         default: begin // SAR
            sext = msb ? mask : 32'd0;
            if (nc >= n) begin r = sext; c = msb; end
            else begin r = ((s >> nc) | (sext << (n - nc))) & mask; c = s[nc-1]; end
            o = 1'b0;
         end
      endcase
      fo.c = c;
      fo.o = o;
      if (op inside {OP_SHL, OP_SAL, OP_SHR, OP_SAR}) begin
         fo.p = ~^r[7:0];
         fo.z = (r == 0);
         fo.s = r[n-1];
      end
      res = r[15:0];
   endfunction

   task automatic launch(shift_op_t op, bit w, logic [15:0] s, logic [7:0] c, flags_t f);
      @(negedge clock);
      opcode = op; select_word = w; source = s; count = c; source_flags = f; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // bounded wait for done; lat counts clocks since the start edge
   task automatic wait_done(inout int lat);
      while (done !== 1'b1 && lat < 400) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   function automatic int eff_count(logic [7:0] c);
`ifdef KFX86_SHIFT_COUNT_MASK_EN
      return int'(c & 8'h1F);
`else
      return int'(c);
`endif
   endfunction

   vec_t vecs[$];

   initial begin
      int          lat;
      bit          saw_done;
      logic [15:0] mres;
      flags_t      mfl;
      shift_op_t   rop;
      bit          rw;
      logic [15:0] rs;
      logic [7:0]  rc;
      flags_t      rf;

      vecs.push_back(mk("shl_w_8001",  OP_SHL, 1, 16'h8001, 8'd1,  6'b000000, 16'h0002, 6'b100001, 2));
      vecs.push_back(mk("ror_b_01",    OP_ROR, 0, 16'h0001, 8'd3,  6'b000000, 16'h0020, 6'b000000, 4));
      vecs.push_back(mk("sar_w_8000",  OP_SAR, 1, 16'h8000, 8'd15, 6'b000000, 16'hFFFF, 6'b010010, 16));
      vecs.push_back(mk("rcl_b_80",    OP_RCL, 0, 16'h0080, 8'd2,  6'b000000, 16'h0001, 6'b000000, 3));
      vecs.push_back(mk("shr_cnt0",    OP_SHR, 1, 16'h1234, 8'd0,  6'b101101, 16'h1234, 6'b101101, 1));
`ifdef KFX86_SHIFT_COUNT_MASK_EN
      vecs.push_back(mk("shl_cnt33",   OP_SHL, 1, 16'h0001, 8'h21, 6'b000000, 16'h0002, 6'b000000, 2));
`else
      vecs.push_back(mk("shl_cnt33",   OP_SHL, 1, 16'h0001, 8'h21, 6'b000000, 16'h0000, 6'b001010, 34));
`endif
      vecs.push_back(mk("byte_cnt0",   OP_SHL, 0, 16'hABCD, 8'd0,  6'b000000, 16'h00CD, 6'b000000, 1));
      vecs.push_back(mk("shl_b_keepA", OP_SHL, 0, 16'h0081, 8'd1,  6'b000100, 16'h0002, 6'b100101, 2));
      vecs.push_back(mk("rcr_w_cin",   OP_RCR, 1, 16'h0001, 8'd1,  6'b000001, 16'h8000, 6'b100001, 2));
      vecs.push_back(mk("rol_w_8000",  OP_ROL, 1, 16'h8000, 8'd1,  6'b000000, 16'h0001, 6'b100001, 2));
      vecs.push_back(mk("sal_alias",   OP_SAL, 1, 16'h4000, 8'd1,  6'b000000, 16'h8000, 6'b110010, 2));
      vecs.push_back(mk("sar_b_over",  OP_SAR, 0, 16'h0080, 8'd9,  6'b000000, 16'h00FF, 6'b010011, 10));

      reset = 1'b1; start = 1'b0; opcode = OP_ROL; select_word = 1'b0;
      source = '0; count = '0; source_flags = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst result", result, 0);
      check("rst flags", out_flags, 0);
      @(negedge clock); reset = 1'b0;

      // directed table
      foreach (vecs[i]) begin
         launch(vecs[i].op, vecs[i].word, vecs[i].src, vecs[i].cnt, vecs[i].fin);
         lat = 1;
         wait_done(lat);
         check({vecs[i].name, " done"}, done, 1);
         check({vecs[i].name, " lat"}, lat, vecs[i].exp_lat);
         check({vecs[i].name, " res"}, result, vecs[i].exp_res);
         check({vecs[i].name, " flags"}, out_flags, vecs[i].exp_fl);
         @(posedge clock); #1;
         check({vecs[i].name, " pulse"}, done, 0);
         check({vecs[i].name, " hold"}, result, vecs[i].exp_res);
      end

      // reset on the 3rd SHIFT cycle aborts with no done
      launch(OP_SHL, 1, 16'h0001, 8'd10, '0);
      check("abort busy0", busy, 1);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort result", result, 0);
      check("abort flags", out_flags, 0);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (12) begin
         @(posedge clock); #1;
         if (done) saw_done = 1'b1;
      end
      check("abort no done", saw_done, 0);

      // start together with reset is dropped
      @(negedge clock);
      reset = 1'b1; start = 1'b1; opcode = OP_SHL; select_word = 1'b1;
      source = 16'h0001; count = 8'd3;
      @(posedge clock); #1;
      reset = 1'b0; start = 1'b0;
      check("rststart busy", busy, 0);
      @(posedge clock); #1;
      check("rststart busy2", busy, 0);
      check("rststart done", done, 0);

      launch(OP_SHL, 1, 16'h0001, 8'd1, '0);
      lat = 1;
      wait_done(lat);
      check("post rst lat", lat, 2);
      check("post rst res", result, 16'h0002);
      @(posedge clock); #1;

      // start while busy is ignored
      launch(OP_SHL, 1, 16'h0003, 8'd4, '0);
      lat = 1;
      @(negedge clock);
      opcode = OP_ROR; source = 16'hFFFF; count = 8'd1; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat++;
      wait_done(lat);
      check("busy start lat", lat, 5);
      check("busy start res", result, 16'h0030);
      check("busy start flags", out_flags, 6'b000010);
      @(posedge clock); #1;
      check("busy start idle", busy, 0);
      check("busy start nodone", done, 0);

      // randomized against the model
      for (int i = 0; i < 300; i++) begin
         rop = shift_op_t'(3'($urandom_range(0, 7)));
         rw  = 1'($urandom_range(0, 1));
         rs  = 16'($urandom);
         rc  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'($urandom_range(0, 20));
         rf  = flags_t'(6'($urandom));
         model(rop, rw, rs, eff_count(rc), rf, mres, mfl);
         launch(rop, rw, rs, rc, rf);
         lat = 1;
         wait_done(lat);
         check("rnd done", done, 1);
         check("rnd lat", lat, eff_count(rc) + 1);
         check("rnd res", result, mres);
         check("rnd flags", out_flags, mfl);
         @(posedge clock); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
